// File: rtl/sim_controller.sv
// Run controller for the processor simulation: sequences the core reset, counts RUN cycles,
// watches for a tohost store and enforces a watchdog. Optional console report: SIM_CTRL_DISPLAY_EN.
module sim_controller #(
  parameter int unsigned       RESET_CYCLES = 2,
  parameter int unsigned       MAX_CYCLES   = 30,
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       CNT_W        = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 32'h0000_0FFC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              core_rst_n,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [DATA_W-1:0] exit_code,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] exit_code_q, exit_code_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;

  logic tohost_hit;
  assign tohost_hit = mem_we && (mem_addr == TOHOST_ADDR);

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    core_rst_n_d  = core_rst_n_q;
    running_d     = running_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    timeout_d     = timeout_q;
    exit_code_d   = exit_code_q;
    cycle_count_d = cycle_count_q;

    unique case (state_q)
      ST_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d      = ST_RUN;
          core_rst_n_d = 1'b1;
          running_d    = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        // The tohost write is checked first so it wins over a simultaneous watchdog expiry.
        if (tohost_hit) begin
          state_d      = ST_DONE;
          core_rst_n_d = 1'b0;
          running_d    = 1'b0;
          done_d       = 1'b1;
          pass_d       = (mem_wdata == DATA_W'(1));
          fail_d       = (mem_wdata != DATA_W'(1));
          exit_code_d  = mem_wdata >> 1;
        end else if (cycle_count_q == CNT_LAST) begin
          state_d      = ST_DONE;
          core_rst_n_d = 1'b0;
          running_d    = 1'b0;
          done_d       = 1'b1;
          fail_d       = 1'b1;
          timeout_d    = 1'b1;
          exit_code_d  = '0;
        end else begin
          cycle_count_d = cycle_count_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RESET;
      rst_cnt_q     <= '0;
      core_rst_n_q  <= 1'b0;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
      exit_code_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      core_rst_n_q  <= core_rst_n_d;
      running_q     <= running_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      timeout_q     <= timeout_d;
      exit_code_q   <= exit_code_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign core_rst_n  = core_rst_n_q;
  assign running     = running_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign exit_code   = exit_code_q;
  assign cycle_count = cycle_count_q;

`ifdef SIM_CTRL_DISPLAY_EN
  logic done_prev_q;

  // Reports once, on the first cycle done is visible, then ends the simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_prev_q <= 1'b0;
    end else begin
      done_prev_q <= done_q;
      if (done_q && !done_prev_q) begin
        if (timeout_q)
          $display("sim_controller: TIMEOUT after %0d cycles", cycle_count_q);
        else if (pass_q)
          $display("sim_controller: PASS after %0d cycles", cycle_count_q);
        else
          $display("sim_controller: FAIL(%0d) after %0d cycles", exit_code_q, cycle_count_q);
        $finish;
      end
    end
  end
`else
  // No report logic: the environment polls done.
`endif

endmodule

// File: tb/tb_sim_controller.sv
// Randomised scoreboard bench for sim_controller: the stimulus side predicts each run's outcome
// from the write schedule, and a monitor compares it when done rises.
module tb_sim_controller;
  localparam int          RC = 2;
  localparam int          MC = 30;
  localparam int          NS = 40;
  localparam logic [31:0] TH = 32'h0000_0FFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        core_rst_n, running, done, pass, fail, timeout;
  logic [31:0] exit_code, cycle_count;

  sim_controller #(
    .RESET_CYCLES(RC), .MAX_CYCLES(MC), .ADDR_W(32), .DATA_W(32), .CNT_W(32), .TOHOST_ADDR(TH)
  ) dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n), .running(running), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .exit_code(exit_code), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [31:0] exit_code;
    logic [31:0] cycle_count;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   runs  = 0;

  logic        s_we[NS];
  logic [31:0] s_addr[NS];
  logic [31:0] s_data[NS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] other_addr();
    logic [31:0] a;
    a = $urandom;
    if (a == TH) a = a ^ 32'h1;
    return a;
  endfunction

  // Background traffic never contains an enabled write to TH, so it must not end a run.
  task automatic clear_sched(input bit noise);
    for (int i = 0; i < NS; i++) begin
      s_we[i] = 1'b0; s_addr[i] = '0; s_data[i] = '0;
      if (noise) begin
        case ($urandom_range(0, 3))
          0: begin s_we[i] = 1'b1; s_addr[i] = other_addr();   s_data[i] = $urandom; end
          1: begin s_we[i] = 1'b0; s_addr[i] = TH;             s_data[i] = $urandom; end
          2: begin s_we[i] = 1'b1; s_addr[i] = 32'h8000_0FFC;  s_data[i] = 32'h1;    end
          default: ;
        endcase
      end
    end
  endtask

  task automatic set_write(input int i, input logic [31:0] a, input logic [31:0] d);
    s_we[i] = 1'b1; s_addr[i] = a; s_data[i] = d;
  endtask

  task automatic drive_junk(input bit hit);
    mem_we    = hit ? 1'b1 : 1'($urandom_range(0, 1));
    mem_addr  = hit ? TH : other_addr();
    mem_wdata = $urandom_range(0, 1) ? 32'h1 : $urandom;
  endtask

  // abort_at < 0: run to completion; otherwise rst is sampled at RUN cycle abort_at.
  task automatic run_sched(input int abort_at);
    exp_t e;
    int   hit;
    hit = -1;
    for (int i = 0; i < MC; i++)
      if (hit < 0 && s_we[i] && s_addr[i] == TH) hit = i;
    e = '0;
    if (hit >= 0) begin
      e.pass        = (s_data[hit] == 32'h1);
      e.fail        = (s_data[hit] != 32'h1);
      e.exit_code   = s_data[hit] >> 1;
      e.cycle_count = 32'(hit);
    end else begin
      e.fail        = 1'b1;
      e.timeout     = 1'b1;
      e.cycle_count = 32'(MC - 1);
    end
    if (abort_at < 0) exp_q.push_back(e);

    rst = 1'b1;
    drive_junk(1'b1);
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 0; j < RC; j++) begin
      drive_junk($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end
    for (int i = 0; i < NS; i++) begin
      if (i == abort_at) begin
        rst = 1'b1; mem_we = 1'b0;
        @(posedge clk); #1;
        return;
      end
      mem_we = s_we[i]; mem_addr = s_addr[i]; mem_wdata = s_data[i];
      @(posedge clk); #1;
    end
    for (int j = 0; j < 3; j++) begin
      drive_junk(1'b1);
      @(posedge clk); #1;
    end
    mem_we = 1'b0;
  endtask

  initial begin
    int k, a;
    logic [31:0] d;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    clear_sched(1'b0); set_write(10, TH, 32'h1); run_sched(-1);
    clear_sched(1'b0); set_write(4, 32'hFF8, 32'h1); set_write(12, TH, 32'h7); run_sched(-1);
    clear_sched(1'b0); set_write(33, TH, 32'h1); run_sched(-1);
    clear_sched(1'b0); set_write(29, TH, 32'h1); run_sched(-1);
    clear_sched(1'b0); run_sched(5);
    clear_sched(1'b0); set_write(10, TH, 32'h1); run_sched(-1);

    for (int n = 0; n < 40; n++) begin
      clear_sched(1'b1);
      k = $urandom_range(0, NS - 1);
      case ($urandom_range(0, 3))
        0, 1:    d = 32'h1;
        2:       d = $urandom_range(0, 15);
        default: d = $urandom;
      endcase
      set_write(k, TH, d);
      a = -1;
      if ($urandom_range(0, 7) == 0) a = $urandom_range(0, (k < MC) ? k : MC - 1);
      run_sched(a);
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  int   rst_s = 1;
  int   rel_edges = 0;
  logic prev_done = 1'b0;
  logic prev_core = 1'b0;
  exp_t snap;
  logic snap_core, snap_run;

  always @(posedge clk) begin
    rst_s = rst ? 1 : 0;
    if (rst) rel_edges = 0;
    else     rel_edges = rel_edges + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_s != 0) begin
      chk("reset_clear",
          {30'd0, core_rst_n, running, done, pass, fail, timeout, exit_code[0], cycle_count[0]}
            | 64'(exit_code) | 64'(cycle_count), 64'd0);
    end else begin
      chk("done_is_pass_or_fail", 64'(done), 64'(pass | fail));
      chk("pass_fail_exclusive", 64'(pass & fail), 64'd0);
      if (core_rst_n && !prev_core) begin
        chk("core_rst_n_release_edge", 64'(rel_edges), 64'(RC));
        chk("run_start_state", {cycle_count, 29'd0, running, done, timeout},
            {32'd0, 29'd0, 1'b1, 1'b0, 1'b0});
      end
      if (done && !prev_done) begin
        runs++;
        $display("run %0d: pass=%0b fail=%0b timeout=%0b exit=%0h cycles=%0d",
                 runs, pass, fail, timeout, exit_code, cycle_count);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pass", 64'(pass), 64'(e.pass));
          chk("fail", 64'(fail), 64'(e.fail));
          chk("timeout", 64'(timeout), 64'(e.timeout));
          chk("exit_code", 64'(exit_code), 64'(e.exit_code));
          chk("cycle_count", 64'(cycle_count), 64'(e.cycle_count));
          chk("frozen_on_done", {62'd0, core_rst_n, running}, 64'd0);
        end
        snap      = {pass, fail, timeout, exit_code, cycle_count};
        snap_core = core_rst_n;
        snap_run  = running;
      end else if (done && prev_done) begin
        chk("done_hold", 64'({pass, fail, timeout, exit_code, cycle_count} != snap), 64'd0);
        chk("done_hold_ctl", {62'd0, core_rst_n, running}, {62'd0, snap_core, snap_run});
      end
    end
    prev_done = done;
    prev_core = core_rst_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d runs expected completion", runs);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/sim_controller.md
# sim_controller

Parametrised run controller for the RISC-V processor simulation environment. It sequences the core's active-low reset, counts execution cycles, watches the data-memory write bus for a `tohost` store, and enforces a watchdog limit. It replaces fixed delay-based run control with deterministic pass/fail/timeout reporting. It sits beside `processador`: it drives the core's `rst_n` and snoops the core's data-store port.

## Interface
- `RESET_CYCLES`, 2: cycles `core_rst_n` is held low after `rst` deasserts; must be ≥1.
- `MAX_CYCLES`, 30: watchdog limit in RUN cycles; must be ≥1.
- `ADDR_W`, 32: memory address width.
- `DATA_W`, 32: memory data width.
- `CNT_W`, 32: cycle counter width; must satisfy 2^CNT_W > MAX_CYCLES.
- `TOHOST_ADDR`, 32'h0000_0FFC: store address that signals test completion.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_we` in 1: core data-memory write enable.
- `mem_addr` in ADDR_W: core data-memory address.
- `mem_wdata` in DATA_W: core data-memory write data.
- `core_rst_n` out 1: active-low reset to `processador`.
- `running` out 1: high while in RUN.
- `done` out 1: test finished, equal to `pass | fail`.
- `pass` out 1: `tohost` write of value 1.
- `fail` out 1: `tohost` write of any other value, or timeout.
- `timeout` out 1: watchdog expired.
- `exit_code` out DATA_W: `mem_wdata >> 1` from the `tohost` write, or 0 on timeout.
- `cycle_count` out CNT_W: RUN cycles elapsed.

## Operation
- FSM states: RESET, RUN, DONE. All outputs are registered.
- `rst`=1 at a posedge, from any state and including mid-run:
  - state goes to RESET and the reset counter clears to 0.
  - `core_rst_n`=0.
  - `running`, `done`, `pass`, `fail` and `timeout` all go to 0.
  - `exit_code`=0 and `cycle_count`=0.
- RESET, at each posedge with `rst`=0:
  - If the reset counter equals RESET_CYCLES-1: go to RUN, set `core_rst_n`=1 and `running`=1.
  - Otherwise increment the reset counter.
  - Bus writes are ignored in this state.
- RUN, at each posedge, evaluated in priority order:
  1. `mem_we` && `mem_addr`==TOHOST_ADDR: go to DONE.
     - `pass` = (`mem_wdata`==1), `fail` = !pass.
     - `exit_code` = `mem_wdata` >> 1 (zero-filled).
  2. Else if `cycle_count`==MAX_CYCLES-1: go to DONE with `timeout`=1, `fail`=1, `exit_code`=0.
  3. Else increment `cycle_count`.
- Simultaneous `tohost` write and watchdog expiry: the write wins and `timeout` stays 0.
- Writes to other addresses have no effect.
- Entering DONE sets `core_rst_n`=0 (this freezes the core) and `running`=0.
- DONE:
  - All status outputs and `cycle_count` hold.
  - Bus input is ignored.
  - The FSM leaves DONE only via `rst`.
- Width rules:
  - `mem_addr` is compared over the full ADDR_W bits.
  - `cycle_count` never wraps, because the watchdog stops it at MAX_CYCLES-1.

## Timing
- `core_rst_n` rises on the RESET_CYCLES-th posedge that samples `rst`=0.
- The first RUN cycle shows `cycle_count`=0.
- Completion latency: `done`/`pass`/`fail` are asserted the cycle after the posedge that samples the `tohost` write. No combinational path exists from bus to outputs.
- Timeout latency: `timeout` is asserted on the MAX_CYCLES-th posedge in RUN, with `cycle_count`=MAX_CYCLES-1 held.
- `pass` and `fail` are mutually exclusive and never toggle after being set.

## Configuration
- `SIM_CTRL_DISPLAY_EN` defined:
  - On the cycle `done` rises, execute `$display` of PASS / FAIL(`exit_code`) / TIMEOUT together with `cycle_count`.
  - Then call `$finish`.
- Undefined: no system tasks are compiled in. The block is pure synthesizable RTL and the bench polls `done`.

## Test plan
All scenarios use RESET_CYCLES=2, MAX_CYCLES=30, TOHOST_ADDR=0xFFC.
- Reset sequencing: `rst`=1 for 3 cycles, then 0 → `core_rst_n` stays 0 for 1 edge and rises on the 2nd edge; `running`=1 and `cycle_count`=0.
- Pass: write 0x1 to 0xFFC at RUN cycle 10 → next cycle `done`=1, `pass`=1, `fail`=0, `exit_code`=0, `cycle_count`=10, `core_rst_n`=0.
- Fail code: write 0x7 to 0xFFC → `fail`=1, `exit_code`=3. A prior write of 0x1 to 0xFF8 causes no effect.
- Timeout: no `tohost` write → `timeout`=1, `fail`=1, `cycle_count`=29; further writes to 0xFFC are ignored.
- Priority: write 0x1 to 0xFFC on the cycle `cycle_count`=29 → `pass`=1, `timeout`=0.
- Reset mid-run: assert `rst` at RUN cycle 5 → all outputs clear next cycle and the full sequence restarts identically.
